// File: rtl/hal_mux_pkg.sv
// Shared constants and helpers for the N-way mux/arbiter family.
// Mode encodings and the channel-index width rule live here.
package hal_mux_pkg;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

    function automatic int ch_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hal_rr_arb.sv
// Round-robin grant: pointer register, wrapped search, one-hot grant.
// The pointer moves past the winner only when the grant is taken.
module hal_rr_arb
    import hal_mux_pkg::*;
#(
    parameter int N = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int CW = ch_width(N);

    logic [CW-1:0] ptr;
    logic [CW-1:0] gidx;
    logic          found;

    function automatic logic [CW-1:0] wrap_idx(
        input logic [CW-1:0] p,
        input int            k
    );
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return CW'(s);
    endfunction

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && valid[wrap_idx(ptr, k)]) begin
                found = 1'b1;
                gidx  = wrap_idx(ptr, k);
            end
        end
        grant = '0;
        if (found) grant[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(gidx) == N - 1) ? '0 : gidx + CW'(1);
        end
    end

endmodule

// File: rtl/hal_muxn_arb.sv
// N-channel valid/ready mux into one output register stage,
// with explicit select or round-robin channel choice.
module hal_muxn_arb
    import hal_mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = 0,
    localparam int CW   = ch_width(N)
)
(
    input  logic           CLK,
    input  logic           RST,
    input  logic [N*W-1:0] IN_DATA,
    input  logic [N-1:0]   IN_VALID,
    output logic [N-1:0]   IN_READY,
    input  logic [CW-1:0]  SEL,
    output logic [W-1:0]   OUT_DATA,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [CW-1:0]  OUT_CH
);

    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("hal_muxn_arb: N=%0d outside 2..16", N);
        end
        if (W < 1 || W > 64) begin : g_bad_w
            $error("hal_muxn_arb: W=%0d outside 1..64", W);
        end
        if (MODE != MODE_SELECT && MODE != MODE_RR) begin : g_bad_mode
            $error("hal_muxn_arb: MODE=%0d unsupported", MODE);
        end
    endgenerate

    logic          can_accept;
    logic          accept;
    logic [N-1:0]  cand;
    logic [W-1:0]  win_data;
    logic [CW-1:0] win_ch;

    assign can_accept = !OUT_VALID || OUT_READY;

    generate
        if (MODE == MODE_RR) begin : g_rr
            hal_rr_arb #(.N(N)) u_arb (
                .clk     (CLK),
                .rst     (RST),
                .valid   (IN_VALID),
                .advance (accept),
                .grant   (cand)
            );
        end else begin : g_sel
            // Out-of-range SEL matches no channel, so nothing is offered.
            always_comb begin
                cand = '0;
                for (int i = 0; i < N; i++) begin
                    cand[i] = (int'(SEL) == i);
                end
            end
        end
    endgenerate

    assign IN_READY = RST ? '0 : (cand & {N{can_accept}});
    assign accept   = |(IN_VALID & IN_READY);

    always_comb begin
        win_data = '0;
        win_ch   = '0;
        for (int i = 0; i < N; i++) begin
            if (IN_READY[i]) begin
                win_data = IN_DATA[i*W +: W];
                win_ch   = CW'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
        end else if (accept) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= win_data;
            OUT_CH    <= win_ch;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hal_muxn_arb.sv
// Bench for hal_muxn_arb: select mode (N=4, N=3) and round-robin mode,
// vector table plus scoreboard of expected output words.
module tb_hal_muxn_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] d0_in;
    logic [3:0]  d0_v, d0_r;
    logic [1:0]  d0_sel, d0_ch;
    logic [7:0]  d0_od;
    logic        d0_ov, d0_ordy;

    logic [31:0] d1_in;
    logic [3:0]  d1_v, d1_r;
    logic [1:0]  d1_sel, d1_ch;
    logic [7:0]  d1_od;
    logic        d1_ov, d1_ordy;

    logic [23:0] d2_in;
    logic [2:0]  d2_v, d2_r;
    logic [1:0]  d2_sel, d2_ch;
    logic [7:0]  d2_od;
    logic        d2_ov, d2_ordy;

    hal_muxn_arb #(.N(4), .W(8), .MODE(0)) u_d0 (
        .CLK(clk), .RST(rst), .IN_DATA(d0_in), .IN_VALID(d0_v),
        .IN_READY(d0_r), .SEL(d0_sel), .OUT_DATA(d0_od),
        .OUT_VALID(d0_ov), .OUT_READY(d0_ordy), .OUT_CH(d0_ch)
    );

    hal_muxn_arb #(.N(4), .W(8), .MODE(1)) u_d1 (
        .CLK(clk), .RST(rst), .IN_DATA(d1_in), .IN_VALID(d1_v),
        .IN_READY(d1_r), .SEL(d1_sel), .OUT_DATA(d1_od),
        .OUT_VALID(d1_ov), .OUT_READY(d1_ordy), .OUT_CH(d1_ch)
    );

    hal_muxn_arb #(.N(3), .W(8), .MODE(0)) u_d2 (
        .CLK(clk), .RST(rst), .IN_DATA(d2_in), .IN_VALID(d2_v),
        .IN_READY(d2_r), .SEL(d2_sel), .OUT_DATA(d2_od),
        .OUT_VALID(d2_ov), .OUT_READY(d2_ordy), .OUT_CH(d2_ch)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  v;
        logic        ordy;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic        ov;
        logic [7:0]  od;
    } vec_t;

    vec_t tbl[16];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: output transfer with no expected word", nm);
    endtask

    // Outputs seen valid+ready at the falling edge transfer at the next rise.
    always @(negedge clk) begin
        exp_t e;
        if (d0_ov && d0_ordy) begin
            if (q0.size() == 0) miss("sb0");
            else begin
                e = q0.pop_front();
                chk("sb0_data", 64'(d0_od), 64'(e.d));
                chk("sb0_ch", 64'(d0_ch), 64'(e.ch));
            end
        end
        if (d1_ov && d1_ordy) begin
            if (q1.size() == 0) miss("sb1");
            else begin
                e = q1.pop_front();
                chk("sb1_data", 64'(d1_od), 64'(e.d));
                chk("sb1_ch", 64'(d1_ch), 64'(e.ch));
            end
        end
        if (d2_ov && d2_ordy) begin
            if (q2.size() == 0) miss("sb2");
            else begin
                e = q2.pop_front();
                chk("sb2_data", 64'(d2_od), 64'(e.d));
                chk("sb2_ch", 64'(d2_ch), 64'(e.ch));
            end
        end
    end

    task automatic rr_step(input logic [3:0] v, input logic ordy,
                           input logic [3:0] er);
        d1_v    = v;
        d1_ordy = ordy;
        d1_in   = $urandom();
        #1;
        chk("rr_ready", 64'(d1_r), 64'(er));
        for (int i = 0; i < 4; i++) begin
            if (v[i] && er[i]) q1.push_back('{d: d1_in[i*8 +: 8], ch: 2'(i)});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{2'd2, 4'b1111, 1'b1, 32'h11A53344, 4'b0100, 1'b0, 8'h00};
        tbl[1]  = '{2'd0, 4'b0001, 1'b1, 32'h00000077, 4'b0001, 1'b1, 8'hA5};
        tbl[2]  = '{2'd1, 4'b0000, 1'b1, 32'h00009900, 4'b0010, 1'b1, 8'h77};
        tbl[3]  = '{2'd3, 4'b1000, 1'b0, 32'h3C000000, 4'b1000, 1'b0, 8'h00};
        for (int i = 4; i < 9; i++)
            tbl[i] = '{2'd1, 4'b0010, 1'b0, 32'h00005A00, 4'b0000, 1'b1, 8'h3C};
        tbl[9]  = '{2'd1, 4'b0010, 1'b1, 32'h00005A00, 4'b0010, 1'b1, 8'h3C};
        tbl[10] = '{2'd2, 4'b0000, 1'b1, 32'h00660000, 4'b0100, 1'b1, 8'h5A};
        tbl[11] = '{2'd0, 4'b0001, 1'b0, 32'h000000E1, 4'b0001, 1'b0, 8'h00};
        tbl[12] = '{2'd0, 4'b0001, 1'b1, 32'h000000E2, 4'b0001, 1'b1, 8'hE1};
        tbl[13] = '{2'd3, 4'b1000, 1'b1, 32'hE3000000, 4'b1000, 1'b1, 8'hE2};
        tbl[14] = '{2'd0, 4'b0000, 1'b1, 32'h00000000, 4'b0001, 1'b1, 8'hE3};
        tbl[15] = '{2'd0, 4'b0000, 1'b0, 32'h00000000, 4'b0001, 1'b0, 8'h00};

        rst = 1'b1;
        d0_in = '0; d0_v = '0; d0_sel = '0; d0_ordy = 1'b0;
        d1_in = '0; d1_v = '0; d1_sel = '0; d1_ordy = 1'b0;
        d2_in = '0; d2_v = '0; d2_sel = '0; d2_ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        d0_v = '1; d0_ordy = 1'b1; d0_sel = 2'd1;
        d1_v = '1; d1_ordy = 1'b1;
        d2_v = '1; d2_ordy = 1'b1;
        #1;
        chk("rst_ready0", 64'(d0_r), 64'd0);
        chk("rst_ready1", 64'(d1_r), 64'd0);
        chk("rst_ready2", 64'(d2_r), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_out0", 64'({d0_ov, d0_od, d0_ch}), 64'd0);
        chk("rst_out1", 64'({d1_ov, d1_od, d1_ch}), 64'd0);
        chk("rst_out2", 64'({d2_ov, d2_od, d2_ch}), 64'd0);
        rst = 1'b0;
        d1_v = '0;
        d2_v = '0;

        for (int i = 0; i < 16; i++) begin
            d0_sel  = tbl[i].sel;
            d0_v    = tbl[i].v;
            d0_ordy = tbl[i].ordy;
            d0_in   = tbl[i].data;
            #1;
            chk("sel_ready", 64'(d0_r), 64'(tbl[i].rdy));
            chk("sel_ovalid", 64'(d0_ov), 64'(tbl[i].ov));
            if (tbl[i].ov) chk("sel_odata", 64'(d0_od), 64'(tbl[i].od));
            for (int c = 0; c < 4; c++) begin
                if (tbl[i].v[c] && tbl[i].rdy[c])
                    q0.push_back('{d: d0_in[c*8 +: 8], ch: 2'(c)});
            end
            @(posedge clk);
            #1;
        end
        d0_v = '0;
        d0_ordy = 1'b1;

        for (int k = 0; k < 8; k++) rr_step(4'b1111, 1'b1, 4'b0001 << (k % 4));
        rr_step(4'b0100, 1'b1, 4'b0100);
        rr_step(4'b0010, 1'b1, 4'b0010);
        rr_step(4'b1010, 1'b1, 4'b1000);
        rr_step(4'b0000, 1'b1, 4'b0000);
        rr_step(4'b0001, 1'b0, 4'b0001);
        rr_step(4'b1111, 1'b0, 4'b0000);
        chk("rr_hold_valid", 64'(d1_ov), 64'd1);

        d2_sel = 2'd3; d2_v = 3'b111; d2_ordy = 1'b1; d2_in = $urandom();
        #1;
        chk("n3_sel3_ready", 64'(d2_r), 64'd0);
        @(posedge clk);
        #1;
        chk("n3_sel3_ovalid", 64'(d2_ov), 64'd0);
        d2_sel = 2'd2; d2_in = $urandom();
        #1;
        chk("n3_sel2_ready", 64'(d2_r), 64'b100);
        q2.push_back('{d: d2_in[23:16], ch: 2'd2});
        @(posedge clk);
        #1;
        chk("n3_sel2_ovalid", 64'(d2_ov), 64'd1);
        d2_sel = 2'd0; d2_v = '0;
        #1;
        chk("n3_idle_ready", 64'(d2_r), 64'b001);
        @(posedge clk);
        #1;
        chk("n3_drained", 64'(d2_ov), 64'd0);

        d0_sel = 2'd1; d0_v = 4'b0010; d0_ordy = 1'b0; d0_in = 32'h00003C00;
        #1;
        chk("pre_rst_ready", 64'(d0_r), 64'b0010);
        @(posedge clk);
        #1;
        chk("pre_rst_hold", 64'({d0_ov, d0_od}), 64'h13C);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready0", 64'(d0_r), 64'd0);
        chk("mid_rst_ready1", 64'(d1_r), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_out0", 64'({d0_ov, d0_od, d0_ch}), 64'd0);
        chk("post_rst_out1", 64'({d1_ov, d1_od, d1_ch}), 64'd0);
        q0.delete();
        q1.delete();
        d0_v = '0;
        rr_step(4'b1111, 1'b1, 4'b0001);
        rr_step(4'b0000, 1'b1, 4'b0000);
        @(posedge clk);
        #1;

        chk("q0_left", 64'(q0.size()), 64'd0);
        chk("q1_left", 64'(q1.size()), 64'd0);
        chk("q2_left", 64'(q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hal_muxn_arb.md
HAL_MUXN_ARB -- requirements
Module: hal_muxn_arb

Interface
REQ-001 SHALL have parameter N, default 4, the number of input channels (legal range 2..16).
REQ-002 SHALL have parameter W, default 8, the data width per channel (legal range 1..64).
REQ-003 SHALL have parameter MODE, default 0, where 0 = explicit select and 1 = round-robin arbitration.
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 SHALL have port CLK, input, width 1, the clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, width 1, the synchronous active-high reset.
REQ-007 SHALL have port IN_DATA, input, width N*W, where channel i occupies bits [i*W+W-1 : i*W].
REQ-008 SHALL have port IN_VALID, input, width N, the per-channel valid.
REQ-009 SHALL have port IN_READY, output, width N, the per-channel ready.
REQ-010 SHALL have port SEL, input, width CW = max(1, clog2(N)), the channel select (MODE 0 only; ignored in MODE 1).
REQ-011 SHALL have port OUT_DATA, output, width W, the registered data.
REQ-012 SHALL have port OUT_VALID, output, width 1, the output valid.
REQ-013 SHALL have port OUT_READY, input, width 1, the downstream ready.
REQ-014 SHALL have port OUT_CH, output, width CW, the source channel index of OUT_DATA.

Function
REQ-015 SHALL transfer on an input channel i when IN_VALID[i] and IN_READY[i] are both high at a rising edge; the output transfers when OUT_VALID and OUT_READY are both high.
REQ-016 SHALL hold a single output register stage; can_accept = !OUT_VALID || OUT_READY.
REQ-017 SHALL give a latency of exactly 1 cycle: data accepted at edge k appears on OUT_DATA/OUT_CH with OUT_VALID=1 after edge k.
REQ-018 SHALL assert at most one IN_READY bit in any cycle.
REQ-019 SHALL compute IN_READY combinationally from the current state, SEL/IN_VALID and OUT_READY, without a combinational path from IN_DATA.
REQ-020 In MODE 0, SHALL set IN_READY[i] = can_accept && (SEL == i).
REQ-021 In MODE 0, SHALL keep every IN_READY bit low when SEL >= N (N not a power of two).
REQ-022 In MODE 1, SHALL grant g, the first index with IN_VALID high, searching upward from pointer P with wrap N-1 -> 0.
REQ-023 In MODE 1, SHALL set IN_READY[g] = can_accept, and keep all IN_READY bits low when no IN_VALID bit is high.
REQ-024 In MODE 1, SHALL update P to (g+1) mod N only on an accepted transfer; P is otherwise unchanged.
REQ-025 While OUT_VALID=1 and OUT_READY=0, SHALL keep OUT_DATA and OUT_CH stable and keep all IN_READY bits low.
REQ-026 On a simultaneous output drain and input accept (back-to-back), SHALL load the new word in the same edge so that OUT_VALID stays 1 with no bubble.
REQ-027 SHALL clear OUT_VALID after an edge where the output drains and no input is accepted.
REQ-028 SHALL sustain a throughput of 1 word/cycle while OUT_READY is held high.

Reset
REQ-029 While RST=1 at a rising edge, SHALL clear OUT_VALID=0, OUT_DATA=0, OUT_CH=0 and P=0.
REQ-030 While RST=1, SHALL force all IN_READY bits low, regardless of other inputs.
REQ-031 On a reset mid-transfer, SHALL discard the held word; no output transfer occurs in the reset cycle.
REQ-032 SHALL allow the first accept at the first edge with RST=0.

Structure
REQ-033 SHALL take from shared package hal_mux_pkg: the MODE_SELECT=0 / MODE_RR=1 constants and a channel-index width function returning max(1, clog2(N)).
REQ-034 SHALL place the round-robin grant logic (P register, wrap search, one-hot grant) in sub-module hal_rr_arb, parametrised by N, instantiated only when MODE=1.
REQ-035 SHALL flag an illegal N, W or MODE with an elaboration-time error.

Verification
REQ-036 SHALL cover: N=4, W=8, MODE 0, SEL=2, IN_VALID=4'b1111, ch2 data 8'hA5, OUT_READY=1 -> IN_READY=4'b0100; next cycle OUT_DATA=8'hA5, OUT_CH=2, OUT_VALID=1.
REQ-037 SHALL cover: MODE 0, OUT_VALID=1 holding 8'h3C, OUT_READY=0 for 5 cycles -> OUT_DATA stays 8'h3C and IN_READY=0 throughout; on OUT_READY=1, next word loaded with no bubble.
REQ-038 SHALL cover: MODE 1, N=4, all valid, OUT_READY=1 for 8 cycles -> OUT_CH sequence 0,1,2,3,0,1,2,3.
REQ-039 SHALL cover: MODE 1, P=3, IN_VALID=4'b0010 -> grant ch1, P becomes 2; then IN_VALID=4'b1010 -> grant ch3.
REQ-040 SHALL cover: N=3, MODE 0, SEL=3 -> IN_READY=3'b000 and OUT_VALID stays 0.
REQ-041 SHALL cover: RST=1 for one cycle while OUT_VALID=1 with OUT_READY=0 -> OUT_VALID=0, OUT_DATA=0, OUT_CH=0; in MODE 1 the next grant starts from ch0.
